// File: rtl/jtag_master.sv
// jtag_master: JTAG TAP master issuing IR scans, DR scans and TAP resets from a request port.
// Optional macro JTAG_MASTER_PAUSE_EN routes DR scans through Pause-DR before Update-DR.
module jtag_master #(
  parameter int HALF_DIV = 1,
  parameter int IR_LEN   = 4,
  parameter int DR_MAX   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [4:0]        req_len,
  input  logic [DR_MAX-1:0] req_data,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam logic [1:0] OP_IR  = 2'b00;
  localparam logic [1:0] OP_DR  = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

`ifdef JTAG_MASTER_PAUSE_EN
  localparam logic PAUSE_EN = 1'b1;
`else
  localparam logic PAUSE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {BOOT_RST, IDLE, PRE, SHIFT, POST, DONE} state_t;

  state_t            state, nxt_state;
  logic [4:0]        cnt, nxt_cnt;
  logic [7:0]        div_cnt;
  logic [1:0]        op_r;
  logic [4:0]        len_r, acc_len;
  logic [DR_MAX-1:0] data_r, mask_r, cap_r, nxt_mask;
  logic              last, nxt_tms, nxt_tdi;
  logic              active, half_end, accept;
  logic [4:0]        pre_last, post_last;

  // TMS level driven during period c of state st
  function automatic logic tms_for(state_t st, logic [4:0] c, logic [1:0] op, logic [4:0] len);
    logic t;
    case (st)
      BOOT_RST: t = (c != 5'd5);
      PRE: begin
        if (op == OP_RST)     t = (c != 5'd5);
        else if (op == OP_IR) t = (c < 5'd2);
        else                  t = (c == 5'd0);
      end
      SHIFT: t = (c == len - 5'd1);
      POST: begin
        if (PAUSE_EN && (op == OP_DR)) t = (c == 5'd4) || (c == 5'd5);
        else                           t = (c == 5'd0);
      end
      default: t = 1'b1;
    endcase
    return t;
  endfunction

  assign active   = (state == BOOT_RST) || (state == PRE) || (state == SHIFT) || (state == POST);
  assign half_end = (div_cnt == 8'(HALF_DIV - 1));
  assign accept   = ((state == IDLE) || (state == DONE)) && req_valid && req_ready;
  assign pre_last = (op_r == OP_IR) ? 5'd3 : 5'd2;
  assign post_last = (PAUSE_EN && (op_r == OP_DR)) ? 5'd6 : 5'd1;

  // Effective shift length latched at acceptance
  always_comb begin
    acc_len = 5'd1;
    if (req_op == OP_IR)              acc_len = 5'(IR_LEN);
    else if (req_len == 5'd0)         acc_len = 5'd1;
    else if (int'(req_len) > DR_MAX)  acc_len = 5'(DR_MAX);
    else                              acc_len = req_len;
  end

  // Next TCK period: state, counter and the TMS/TDI levels it needs
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 5'd1;
    last      = 1'b0;
    case (state)
      BOOT_RST: last = (cnt == 5'd5);
      PRE: begin
        if (op_r == OP_RST) begin
          last = (cnt == 5'd5);
        end else if (cnt == pre_last) begin
          nxt_state = SHIFT;
          nxt_cnt   = 5'd0;
        end else begin
          nxt_state = PRE;
        end
      end
      SHIFT: begin
        if (cnt == len_r - 5'd1) begin
          nxt_state = POST;
          nxt_cnt   = 5'd0;
        end else begin
          nxt_state = SHIFT;
        end
      end
      POST:    last = (cnt == post_last);
      default: last = 1'b0;
    endcase
    nxt_mask = (state == SHIFT) ? (mask_r << 1) : mask_r;
    nxt_tms  = tms_for(nxt_state, nxt_cnt, op_r, len_r);
    nxt_tdi  = (nxt_state == SHIFT) ? |(data_r & nxt_mask) : 1'b0;
  end

  // Sequencer: TCK divider, period stepping, TDO capture and request/response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT_RST;
      cnt       <= 5'd0;
      div_cnt   <= 8'd0;
      op_r      <= OP_RST;
      len_r     <= 5'd1;
      data_r    <= '0;
      mask_r    <= DR_MAX'(1);
      cap_r     <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (active) begin
        if (half_end) begin
          div_cnt <= 8'd0;
          tck     <= ~tck;
          if (!tck) begin
            if ((state == SHIFT) && tdo) cap_r <= cap_r | mask_r;
          end else begin
            mask_r <= nxt_mask;
            if (last) begin
              // Boot sequence finishes silently; real ops report through DONE
              state     <= (state == BOOT_RST) ? IDLE : DONE;
              cnt       <= 5'd0;
              tdi       <= 1'b0;
              req_ready <= 1'b1;
              if (state != BOOT_RST) begin
                rsp_valid <= 1'b1;
                rsp_data  <= cap_r;
              end
            end else begin
              state <= nxt_state;
              cnt   <= nxt_cnt;
              tms   <= nxt_tms;
              tdi   <= nxt_tdi;
            end
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end else if (accept) begin
        op_r      <= req_op;
        len_r     <= acc_len;
        data_r    <= req_data;
        mask_r    <= DR_MAX'(1);
        cap_r     <= '0;
        cnt       <= 5'd0;
        div_cnt   <= 8'd0;
        tck       <= 1'b0;
        req_ready <= 1'b0;
        if (req_op == OP_NOP) begin
          state <= IDLE;
        end else begin
          state <= PRE;
          tms   <= 1'b1;
          tdi   <= 1'b0;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end else begin
        req_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master: table of scans against a 1-bit loopback TAP model plus boot, back-to-back and reset-abort sequences.
module tb_jtag_master;
  localparam int DR_MAX = 16;
  localparam int IR_LEN = 4;
`ifdef JTAG_MASTER_PAUSE_EN
  localparam int PAUSE = 1;
`else
  localparam int PAUSE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [4:0]  req_len = 5'd0;
  logic [15:0] req_data = 16'h0000;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_data;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;
  logic        lb_ff = 1'b0;

  int tests = 0;
  int fails = 0;
  int tck_total = 0;
  int rsp_total = 0;
  int bad_change = 0;
  logic tms_hist [0:1023];
  logic tdi_hist [0:1023];

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  len;
    logic [15:0] data;
    int          periods;
    logic [15:0] rsp;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  jtag_master #(.HALF_DIV(1), .IR_LEN(IR_LEN), .DR_MAX(DR_MAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_len(req_len), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // loopback target: capture TDI on rise, present it on TDO at the fall
  always @(posedge tck) lb_ff <= tdi;
  always @(negedge tck) tdo <= lb_ff;

  always @(posedge tck) begin
    if (tck_total < 1024) begin
      tms_hist[tck_total] <= tms;
      tdi_hist[tck_total] <= tdi;
    end
    tck_total <= tck_total + 1;
  end

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_total <= rsp_total + 1;

  always @(tms or tdi) if (tck === 1'b1 && rst === 1'b0) bad_change = bad_change + 1;

  function automatic int n_pre(input logic [1:0] op);
    return (op == 2'b00) ? 4 : (op == 2'b01) ? 3 : 6;
  endfunction

  function automatic int n_shift(input logic [1:0] op, input logic [4:0] len);
    if (op == 2'b00) return IR_LEN;
    if (op == 2'b10) return 0;
    if (len == 5'd0) return 1;
    if (int'(len) > DR_MAX) return DR_MAX;
    return int'(len);
  endfunction

  function automatic logic exp_tms(input logic [1:0] op, input logic [4:0] len, input int p);
    int pre, sh, q;
    pre = n_pre(op);
    sh  = n_shift(op, len);
    if (op == 2'b10) return (p != 5);
    if (p < pre) return (op == 2'b00) ? (p < 2) : (p == 0);
    if (p < pre + sh) return (p == pre + sh - 1);
    q = p - pre - sh;
    if (op == 2'b01 && PAUSE == 1) return (q == 4) || (q == 5);
    return (q == 0);
  endfunction

  function automatic logic exp_tdi(input logic [1:0] op, input logic [4:0] len, input logic [15:0] data, input int p);
    int pre, sh;
    pre = n_pre(op);
    sh  = n_shift(op, len);
    if (op == 2'b10) return 1'b0;
    if (p >= pre && p < pre + sh) return data[p - pre];
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic boot_check(input string tag);
    int k, t0, r0;
    logic [31:0] tv;
    t0 = tck_total; r0 = rsp_total; k = 0;
    @(negedge clk); rst = 1'b0;
    while (req_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check({tag, "_ready_clks"}, k, 12);
    check({tag, "_periods"}, tck_total - t0, 6);
    tv = 32'h0;
    for (int p = 0; p < 6; p++) tv[p] = tms_hist[t0 + p];
    check({tag, "_tms"}, tv, 32'h0000_001F);
    repeat (3) @(negedge clk);
    check({tag, "_no_rsp"}, rsp_total - r0, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k, t0, r0, ep, per;
    logic [31:0] at, et, ad, ed;
    k = 0;
    while (req_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    r0 = rsp_total;
    req_op = v.op; req_len = v.len; req_data = v.data; req_valid = 1'b1;
    @(negedge clk);
    t0 = tck_total;
    req_valid = 1'b0; req_data = ~v.data; req_len = 5'd3; req_op = 2'b10;
    check($sformatf("v%0d_ready_drop", idx), req_ready, 1'b0);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    check($sformatf("v%0d_rsp_seen", idx), rsp_valid, 1'b1);
    check($sformatf("v%0d_rsp_data", idx), rsp_data, v.rsp);
    check($sformatf("v%0d_ready_at_rsp", idx), req_ready, 1'b1);
    ep  = v.periods + ((v.op == 2'b01) ? 5 * PAUSE : 0);
    per = tck_total - t0;
    check($sformatf("v%0d_periods", idx), per, ep);
    at = 32'h0; et = 32'h0; ad = 32'h0; ed = 32'h0;
    for (int p = 0; p < 32; p++) begin
      if (p < per) begin at[p] = tms_hist[t0 + p]; ad[p] = tdi_hist[t0 + p]; end
      if (p < ep)  begin et[p] = exp_tms(v.op, v.len, p); ed[p] = exp_tdi(v.op, v.len, v.data, p); end
    end
    check($sformatf("v%0d_tms", idx), at, et);
    check($sformatf("v%0d_tdi", idx), ad, ed);
    repeat (4) @(negedge clk);
    check($sformatf("v%0d_rsp_count", idx), rsp_total - r0, 1);
  endtask

  initial begin
    int k, t0, r0;
    tbl[0] = '{op: 2'b00, len: 5'd0,  data: 16'h0005, periods: 10, rsp: 16'h000A};
    tbl[1] = '{op: 2'b01, len: 5'd10, data: 16'h0004, periods: 15, rsp: 16'h0008};
    tbl[2] = '{op: 2'b01, len: 5'd0,  data: 16'h0001, periods: 6,  rsp: 16'h0000};
    tbl[3] = '{op: 2'b01, len: 5'd31, data: 16'hA5C3, periods: 21, rsp: 16'h4B86};
    tbl[4] = '{op: 2'b10, len: 5'd7,  data: 16'hFFFF, periods: 6,  rsp: 16'h0000};
    tbl[5] = '{op: 2'b01, len: 5'd16, data: 16'h8001, periods: 21, rsp: 16'h0002};
    tbl[6] = '{op: 2'b00, len: 5'd9,  data: 16'hFFF3, periods: 10, rsp: 16'h0006};

    repeat (3) @(negedge clk);
    check("rst_tck", tck, 1'b0);
    check("rst_tms", tms, 1'b1);
    check("rst_tdi", tdi, 1'b0);
    check("rst_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    boot_check("boot");

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // no-op: accepted, no TCK activity, no response
    t0 = tck_total; r0 = rsp_total;
    req_op = 2'b11; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    check("nop_ready_drop", req_ready, 1'b0);
    repeat (10) @(negedge clk);
    check("nop_tck", tck_total - t0, 0);
    check("nop_rsp", rsp_total - r0, 0);
    check("nop_ready_back", req_ready, 1'b1);

    // back-to-back DR scans with req_valid held high
    t0 = tck_total; r0 = rsp_total;
    req_op = 2'b01; req_len = 5'd4; req_data = 16'h000B; req_valid = 1'b1;
    @(negedge clk);
    req_data = 16'h0006;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 500) begin @(negedge clk); k++; end
    check("b2b_rsp1", rsp_data, 16'h0006);
    check("b2b_ready_done", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_accept_in_done", req_ready, 1'b0);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 500) begin @(negedge clk); k++; end
    check("b2b_rsp2", rsp_data, 16'h000C);
    repeat (4) @(negedge clk);
    check("b2b_rsp_count", rsp_total - r0, 2);
    check("b2b_periods", tck_total - t0, 2 * (9 + 5 * PAUSE));

    // reset during shift period 5 of a 16-bit DR scan
    r0 = rsp_total;
    req_op = 2'b01; req_len = 5'd16; req_data = 16'hFFFF; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    t0 = tck_total; k = 0;
    while ((tck_total - t0) < 9 && k < 200) begin @(negedge clk); k++; end
    check("abort_in_shift5_tdi", tdi, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_tck", tck, 1'b0);
    check("abort_tms", tms, 1'b1);
    check("abort_tdi", tdi, 1'b0);
    check("abort_ready", req_ready, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_rsp_data", rsp_data, 16'h0000);
    repeat (3) @(negedge clk);
    boot_check("reboot");
    check("abort_no_rsp", rsp_total - r0, 0);

    check("pin_change_while_tck_high", bad_change, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 SHALL have parameter HALF_DIV, default 1: clk cycles per TCK half-period (TCK = clk/(2*HALF_DIV)); legal range 1..255.
REQ-002 SHALL have parameter IR_LEN, default 4: instruction register length in bits.
REQ-003 SHALL have parameter DR_MAX, default 16: maximum DR shift length and width of data buses.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block idle and able to accept a request.
REQ-008 req_op  input  2  00 = IR scan, 01 = DR scan, 10 = TAP reset, 11 = no-op (accepted, no TCK activity, no response).
REQ-009 req_len  input  5  DR bit count; ignored for IR and reset ops.
REQ-010 req_data  input  DR_MAX  shift data, LSB shifted first; IR uses bits [IR_LEN-1:0].
REQ-011 rsp_valid  output  1  one-clk pulse: scan complete.
REQ-012 rsp_data  output  DR_MAX  TDO bits captured, LSB first; unused upper bits zero.
REQ-013 TCK, TMS, TDI  output  1 each  JTAG pins to target; TDO  input  1  from target.

Function
REQ-014 SHALL accept a request on a clk edge where req_valid and req_ready are both 1; req_ready SHALL drop the next cycle and stay low until the op ends.
REQ-015 TCK SHALL idle low and toggle only during an op; TMS/TDI SHALL change only on TCK falling edges (or before the first rising edge); TDO SHALL be sampled on TCK rising edges.
REQ-016 FSM states: BOOT_RST, IDLE, PRE, SHIFT, POST, DONE.
REQ-017 TAP reset op TMS sequence per TCK period: 1,1,1,1,1,0 (6 periods), ending in Run-Test/Idle.
REQ-018 IR op TMS sequence: 1,1,0,0 (PRE), IR_LEN shift periods TMS=0 except last TMS=1 (SHIFT), then 1,0 (POST): IR_LEN+6 periods.
REQ-019 DR op TMS sequence: 1,0,0 (PRE), N shift periods TMS=0 except last TMS=1, then 1,0 (POST): N+5 periods.
REQ-020 In SHIFT, TDI SHALL carry req_data[i] during period i; outside SHIFT TDI SHALL be 0.
REQ-021 rsp_data[i] SHALL be TDO sampled at the rising edge of shift period i.
REQ-022 req_len=0 SHALL be treated as 1; req_len>DR_MAX SHALL be clamped to DR_MAX.
REQ-023 On the clk edge ending the last TCK period: rsp_valid=1 for exactly one cycle, rsp_data valid that cycle and held until the next response, req_ready=1 the same cycle.
REQ-024 Back-to-back requests: a request held valid in the DONE cycle SHALL be accepted then; no TCK gap beyond one idle half-period.
REQ-025 req_data/req_op/req_len SHALL be registered at acceptance; later input changes do not affect the op.

Reset
REQ-026 rst SHALL asynchronously force TCK=0, TMS=1, TDI=0, req_ready=0, rsp_valid=0, rsp_data=0, FSM=BOOT_RST.
REQ-027 After rst release the block SHALL autonomously run the REQ-017 sequence, assert no rsp_valid for it, then enter IDLE with req_ready=1.
REQ-028 rst mid-op SHALL abort the op with no response; the boot sequence resynchronises the target TAP.

Configuration
REQ-029 Macro JTAG_MASTER_PAUSE_EN: when defined, DR ops SHALL insert Exit1->Pause-DR: after the last shift bit TMS sequence 0,0,0,0,1,1,0 (N+10 periods total); when undefined, REQ-019 applies unchanged. IR ops are unaffected.

Verification
REQ-030 Release rst, HALF_DIV=1 -> TMS=1 for 5 TCK then 0; req_ready rises after 12 clk; no rsp_valid.
REQ-031 IR op req_data=4'h5 -> 10 TCK periods, TDI pattern 1,0,1,0 in shift periods 0..3, TMS 1,1,0,0,0,0,0,1,1,0; rsp_valid once.
REQ-032 DR op len=10 data=10'b0000000100, TDO looped from TDI through 1-bit delay on TCK fall -> 15 TCK periods, rsp_data = data shifted per loopback model; with JTAG_MASTER_PAUSE_EN, 20 periods.
REQ-033 DR op len=0 and len=31 -> 1 and 16 shift periods respectively.
REQ-034 Two DR ops with req_valid held high -> second accepted in DONE cycle of first; two rsp_valid pulses.
REQ-035 Assert rst during shift period 5 of a 16-bit DR op -> outputs reset immediately, no rsp_valid, boot sequence re-runs.
